// File: rtl/mem_to_axis_if.sv
// AXI-stream beat channel between mem_to_axis and its downstream consumer.
interface mem_to_axis_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mem_to_axis.sv
// Streams a wrap-around span of a synchronous-read memory out as one AXI-stream packet,
// using a credit-limited skid FIFO to absorb the fixed read latency under backpressure.
module mem_to_axis #(
    parameter int  MEMORY_DEPTH = 32,
    parameter int  DATA_WIDTH   = 32,
    parameter int  READ_LATENCY = 1,
    localparam int ADDR_WIDTH   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1,
    localparam int FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    mem_to_axis_if.master         m_axis
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q, last_addr_q;
    logic [LEN_W-1:0]        issue_rem, emit_rem;
    logic [READ_LATENCY-1:0] vld_p;
    logic [INF_W-1:0]        inflight;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    accept, push, pop, last_pop;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(MEMORY_DEPTH - 1)) return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic [INF_W-1:0] popcount(input logic [READ_LATENCY-1:0] v);
        logic [INF_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) n = n + INF_W'(v[i]);
        return n;
    endfunction

    // A read is only issued if its word is guaranteed a FIFO slot on return,
    // counting words already buffered plus those still in the memory pipeline.
    assign inflight = popcount(vld_p);
    assign accept   = (state == IDLE) && start && (length != '0);
    assign rd_en    = (state == ISSUE) && (issue_rem != '0) &&
                      ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    assign rd_addr  = rd_en ? addr_q : last_addr_q;
    assign push     = vld_p[READ_LATENCY-1];

    assign m_axis.tvalid = (fifo_count != '0);
    assign m_axis.tdata  = m_axis.tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_axis.tlast  = m_axis.tvalid && (emit_rem == LEN_W'(1));
    assign pop           = m_axis.tvalid && m_axis.tready;
    assign last_pop      = pop && (emit_rem == LEN_W'(1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (rd_en && (issue_rem == LEN_W'(1))) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            issue_rem   <= '0;
            emit_rem    <= '0;
            vld_p       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last_pop;
            if (accept) begin
                addr_q    <= start_addr;
                issue_rem <= length;
                emit_rem  <= length;
                busy      <= 1'b1;
            end else if (last_pop) begin
                busy <= 1'b0;
            end
            if (rd_en) begin
                addr_q      <= addr_inc(addr_q);
                last_addr_q <= addr_q;
                issue_rem   <= issue_rem - LEN_W'(1);
            end
            if (pop) begin
                emit_rem <= emit_rem - LEN_W'(1);
                rd_ptr   <= ptr_inc(rd_ptr);
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            vld_p      <= (vld_p << 1) | READ_LATENCY'(rd_en);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage is data only; validity is carried entirely by fifo_count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rd_data;
    end
endmodule

// File: tb/tb_mem_to_axis.sv
// Scoreboard bench for mem_to_axis at read latencies 1, 2 and 3 sharing one memory image.
module tb_mem_to_axis;
    localparam int DEPTH = 32;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NI    = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0]          mem [DEPTH];
    logic [NI-1:0]          start, busy, done, rd_en, tvalid, tlast;
    logic                   tready;
    logic [AW-1:0]          start_addr;
    logic [AW:0]            length;
    logic [NI-1:0][AW-1:0]  rd_addr;
    logic [NI-1:0][DW-1:0]  tdata;

    int    total = 0;
    int    bad   = 0;
    int    sel   = 0;
    int    beats = 0;
    int    issued = 0;
    int    emitted = 0;
    beat_t exp_q[$];

    for (genvar g = 0; g < NI; g++) begin : gi
        mem_to_axis_if #(.DATA_WIDTH(DW)) ax ();
        logic [DW-1:0] pipe [g+1];
        logic [DW-1:0] rdat;

        assign ax.tready = tready;
        assign tvalid[g] = ax.tvalid;
        assign tdata[g]  = ax.tdata;
        assign tlast[g]  = ax.tlast;
        assign rdat      = pipe[g];

        always @(posedge clk) begin
            pipe[0] <= rd_en[g] ? mem[rd_addr[g]] : 32'hDEAD_BEEF;
            for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
        end

        mem_to_axis #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(g + 1)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .start_addr(start_addr), .length(length),
            .busy(busy[g]), .done(done[g]), .rd_en(rd_en[g]), .rd_addr(rd_addr[g]),
            .rd_data(rdat), .m_axis(ax)
        );
    end

    task automatic monitor();
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        beat_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                issued     = 0;
                emitted    = 0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (tvalid[sel] !== 1'b1 || tdata[sel] !== prev_data || tlast[sel] !== prev_last) begin
                        bad++;
                        $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b required tvalid=1 tdata=%h tlast=%b",
                                 tvalid[sel], tdata[sel], tlast[sel], prev_data, prev_last);
                    end
                end
                if (rd_en[sel] === 1'b1) begin
                    issued++;
                    total++;
                    if (issued - emitted > sel + 3) begin
                        bad++;
                        $display("FAIL credit: outstanding=%0d required<=%0d", issued - emitted, sel + 3);
                    end
                end
                if (tvalid[sel] === 1'b1 && tready === 1'b1) begin
                    beats++;
                    emitted++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: tdata=%h tlast=%b required no beat", tdata[sel], tlast[sel]);
                    end else begin
                        e = exp_q.pop_front();
                        if (tdata[sel] !== e.d || tlast[sel] !== e.l) begin
                            bad++;
                            $display("FAIL beat: tdata=%h tlast=%b required tdata=%h tlast=%b",
                                     tdata[sel], tlast[sel], e.d, e.l);
                        end
                    end
                end
                prev_stall = (tvalid[sel] === 1'b1) && (tready !== 1'b1);
                prev_data  = tdata[sel];
                prev_last  = tlast[sel];
            end
        end
    endtask

    task automatic push_expected(input int sa, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = mem[(sa + i) % DEPTH];
            b.l = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        int cyc;
        cyc = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done[sel] === 1'b1) begin
                cyc = c;
                break;
            end
            @(posedge clk); #1;
            start = '0;
            if (rnd) tready = 1'($urandom_range(0, 1));
        end
        total++;
        if (cyc < 0) begin
            bad++;
            $display("FAIL %s_timeout: done=0 after %0d cycles required done pulse", tag, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            total++;
            if ({busy[g], done[g], rd_en[g], tvalid[g], tlast[g]} !== 5'b0 || rd_addr[g] !== '0 || tdata[g] !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: busy=%b done=%b rd_en=%b tvalid=%b tlast=%b rd_addr=%0d tdata=%h required all 0",
                         g, busy[g], done[g], rd_en[g], tvalid[g], tlast[g], rd_addr[g], tdata[g]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_rd, exp_v, exp_done, exp_busy;
        sel = 0; tready = 1'b1;
        @(posedge clk); #1;
        push_expected(0, 4);
        start_addr = 0; length = 4; start[0] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_rd   = (c >= 1 && c <= 4);
            exp_v    = (c >= 3 && c <= 6);
            exp_done = (c == 7);
            exp_busy = (c >= 1 && c <= 6);
            total++;
            if (rd_en[0] !== exp_rd || (exp_rd && rd_addr[0] !== AW'(c - 1))) begin
                bad++;
                $display("FAIL basic_rd c%0d: rd_en=%b rd_addr=%0d required rd_en=%b rd_addr=%0d",
                         c, rd_en[0], rd_addr[0], exp_rd, c - 1);
            end
            total++;
            if (tvalid[0] !== exp_v || done[0] !== exp_done || busy[0] !== exp_busy) begin
                bad++;
                $display("FAIL basic_ctl c%0d: tvalid=%b done=%b busy=%b required %b %b %b",
                         c, tvalid[0], done[0], busy[0], exp_v, exp_done, exp_busy);
            end
            @(posedge clk); #1;
            start = '0;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_left: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int addrs[$];
        int exp_a[4] = '{30, 31, 0, 1};
        sel = 0; tready = 1'b1;
        @(posedge clk); #1;
        push_expected(30, 4);
        start_addr = 30; length = 4; start[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_en[0] === 1'b1) addrs.push_back(int'(rd_addr[0]));
            if (done[0] === 1'b1) break;
            @(posedge clk); #1;
            start = '0;
        end
        total++;
        if (addrs.size() != 4) begin
            bad++;
            $display("FAIL wrap_reads: count=%0d required 4", addrs.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= addrs.size() || addrs[i] != exp_a[i]) begin
                bad++;
                $display("FAIL wrap_addr[%0d]: rd_addr=%0d required %0d", i,
                         (i < addrs.size()) ? addrs[i] : -1, exp_a[i]);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_left: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        sel = 1; tready = 1'b1;
        @(posedge clk); #1;
        push_expected(5, 16);
        start_addr = 5; length = 16; start[1] = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start  = '0;
            tready = (c >= 2) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        total++;
        if (issued - emitted != 4 || tvalid[1] !== 1'b1 || busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL bp_stalled: outstanding=%0d tvalid=%b busy=%b required 4 1 1",
                     issued - emitted, tvalid[1], busy[1]);
        end
        wait_done("bp", 400, 1'b1);
        tready = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_left: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        int first, last, done_c, nbeat;
        logic busy_at_done, busy_before;
        sel = 2; tready = 1'b1;
        first = -1; last = -1; done_c = -1; nbeat = 0;
        busy_at_done = 1'bx; busy_before = 1'bx;
        @(posedge clk); #1;
        push_expected(0, 32);
        start_addr = 0; length = 32; start[2] = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (tvalid[2] === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                nbeat++;
            end
            if (done[2] === 1'b1 && done_c < 0) begin
                done_c       = c;
                busy_at_done = busy[2];
            end
            if (c == 36) busy_before = busy[2];
            @(posedge clk); #1;
            start = '0;
        end
        total++;
        if (first != 5 || last != 36 || nbeat != 32) begin
            bad++;
            $display("FAIL full_beats: first=%0d last=%0d beats=%0d required 5 36 32", first, last, nbeat);
        end
        total++;
        if (done_c != 37 || busy_at_done !== 1'b0 || busy_before !== 1'b1) begin
            bad++;
            $display("FAIL full_done: done_cycle=%0d busy_at_done=%b busy_before=%b required 37 0 1",
                     done_c, busy_at_done, busy_before);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_left: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen5, quiet;
        sel = 0; tready = 1'b1; beats = 0; seen5 = 0; quiet = 1;
        @(posedge clk); #1;
        push_expected(0, 10);
        start_addr = 0; length = 10; start[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (beats >= 5) begin
                seen5 = 1;
                break;
            end
            @(posedge clk); #1;
            start = '0;
        end
        total++;
        if (!seen5) begin
            bad++;
            $display("FAIL rstmid_beats: beats=%0d required 5", beats);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (tvalid[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear: tvalid=%b busy=%b done=%b required 0 0 0", tvalid[0], busy[0], done[0]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tvalid[0] !== 1'b0 || done[0] !== 1'b0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rstmid_quiet: stray tvalid/done after reset required none");
        end
        @(posedge clk); #1;
        push_expected(8, 2);
        start_addr = 8; length = 2; start[0] = 1'b1;
        wait_done("rstmid", 20, 1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_left: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_ignored();
        bit idle_ok;
        sel = 0; tready = 1'b1;
        @(posedge clk); #1;
        start_addr = 3; length = 0; start[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
                bad++;
                $display("FAIL ign_len0 c%0d: busy=%b rd_en=%b required 0 0", c, busy[0], rd_en[0]);
            end
            @(posedge clk); #1;
            start = '0;
        end
        push_expected(12, 6);
        start_addr = 12; length = 6; start[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = '0;
            if (c == 3) begin
                start_addr = 0; length = 3; start[0] = 1'b1;
            end
        end
        wait_done("ign", 30, 1'b0);
        idle_ok = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tvalid[0] !== 1'b0 || busy[0] !== 1'b0) idle_ok = 0;
        end
        total++;
        if (!idle_ok || exp_q.size() != 0) begin
            bad++;
            $display("FAIL ign_busy: idle_ok=%b pending=%0d required 1 0", idle_ok, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit hit;
        sel = 1; tready = 1'b1; hit = 0;
        @(posedge clk); #1;
        push_expected(20, 3);
        start_addr = 20; length = 3; start[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done[1] === 1'b1) begin
                push_expected(30, 4);
                start_addr = 30; length = 4; start[1] = 1'b1;
                hit = 1;
                break;
            end
            @(posedge clk); #1;
            start = '0;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL b2b_first: done=0 required done pulse");
        end
        @(posedge clk); #1;
        start = '0;
        @(negedge clk);
        total++;
        if (busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b required 1", busy[1]);
        end
        wait_done("b2b", 30, 1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_left: pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = '0; tready = 1'b1; start_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_full();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t required completion", $time);
        $fatal(1, "timeout");
    end
endmodule
